// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer that walks a simple datapath
// through fetch (T0-T2), operand read (T3), ALU execute (T4) and write-back
// (T5/T6), then retires and either fetches again or returns to IDLE.
//
// Ports:
//   Clock, clear      rising-edge clock, asynchronous active-high reset
//   run               level request to execute instructions back-to-back
//   IR                instruction: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   MemRdy, finished  memory read data valid / ALU result valid
//   PCout..RHIin      datapath strobes, Moore outputs of state
//   RFSelect          register file index (holds outside T3-T5)
//   opSelect          {1'b0, opcode} (holds outside T3-T5)
//   start             ALU start, first T4 cycle only
//   done              one-cycle pulse in the cycle after retire
//   err               sticky abort flag
//   state             current state encoding for debug
//
// Handshake: MemRdy and finished are sampled on every rising Clock while the
// sequencer waits in T1 / T4; a high level seen in the first cycle of the
// state advances with no wait. After TIMEOUT cycles without it, ABORT.
module alu_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        MemRdy,
  input  logic        finished,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        RZin,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        RFout,
  output logic        RYin,
  output logic        RFin,
  output logic        RLOin,
  output logic        RHIin,
  output logic [3:0]  RFSelect,
  output logic [5:0]  opSelect,
  output logic        start,
  output logic        done,
  output logic        err,
  output logic [3:0]  state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_ABORT = 4'd8;

  // Last counter value before a wait gives up.
  localparam logic [6:0] LAST_WAIT = 7'(TIMEOUT - 1);

  logic [3:0] state_q, state_d;
  logic [6:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic [3:0] rfsel_q;
  logic [5:0] opsel_q;

  logic [4:0] opcode;
  logic       legal_op;
  logic       mul_div;
  logic       unused_ir_bits;

  assign opcode         = IR[31:27];
  assign mul_div        = (opcode == 5'b01111) || (opcode == 5'b10000);
  assign unused_ir_bits = ^IR[14:0];

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010,
      5'b01111, 5'b10000, 5'b11101: legal_op = 1'b1;
      default:                      legal_op = 1'b0;
    endcase
  end

  // Next state. The wait counter defaults to zero so that every entry into
  // T1/T4 starts from zero; it only counts up while a wait state is held.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (MemRdy)                        state_d = S_T2;
        else if (wait_cnt_q == LAST_WAIT)  state_d = S_ABORT;
        else                               wait_cnt_d = wait_cnt_q + 7'd1;
      end
      S_T2:   state_d = S_T3;
      S_T3:   state_d = legal_op ? S_T4 : S_ABORT;
      S_T4: begin
        if (finished)                      state_d = S_T5;
        else if (wait_cnt_q == LAST_WAIT)  state_d = S_ABORT;
        else                               wait_cnt_d = wait_cnt_q + 7'd1;
      end
      S_T5: begin
        if (mul_div) begin
          state_d = S_T6;
        end else begin
          state_d = run ? S_T0 : S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_T6: begin
        state_d = run ? S_T0 : S_IDLE;
        done_d  = 1'b1;
      end
      S_ABORT: state_d = S_ABORT;
      default: state_d = S_IDLE;
    endcase
    err_d = err_q | (state_d == S_ABORT);
  end

  // Moore strobes; PCin and start use the zeroed wait counter to mark the
  // first cycle of T1 / T4.
  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; RZin = 1'b0;
    RZLOout = 1'b0; RZHIout = 1'b0; PCin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; RFout = 1'b0;
    RYin = 1'b0; RFin = 1'b0; RLOin = 1'b0; RHIin = 1'b0;
    start    = 1'b0;
    RFSelect = rfsel_q;
    opSelect = opsel_q;
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
      end
      S_T1: begin
        RZLOout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = (wait_cnt_q == '0);
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        RFSelect = IR[22:19];
        opSelect = {1'b0, opcode};
        RFout = 1'b1; RYin = 1'b1;
      end
      S_T4: begin
        RFSelect = IR[18:15];
        opSelect = {1'b0, opcode};
        RFout = 1'b1; RZin = 1'b1;
        start = (wait_cnt_q == '0);
      end
      S_T5: begin
        opSelect = {1'b0, opcode};
        RZLOout  = 1'b1;
        if (mul_div) begin
          RLOin = 1'b1;
        end else begin
          RFSelect = IR[26:23];
          RFin     = 1'b1;
        end
      end
      S_T6: begin
        RZHIout = 1'b1; RHIin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rfsel_q    <= '0;
      opsel_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rfsel_q    <= RFSelect;
      opsel_q    <= opSelect;
    end
  end

  assign done  = done_q;
  assign err   = err_q;
  assign state = state_q;

endmodule
